// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Sequencing stage that sits directly upstream of the per-instruction
// decoders. It owns the program counter, the instruction register and the
// 2-bit micro-state register. It fetches one instruction word over a req/ack
// handshake and then lets the decoders drive PC and micro-state updates until
// the decoder signals completion (next_state == 2'b00).
//
// Ports
//   clock          in   system clock; every state update is on its rising edge
//   reset          in   synchronous active-high reset
//   psel           in   PC update select: 00 hold, 01 pc+4, 10 bus_in, 11 branch
//   pc_sel         in   branch offset source: 1 = k, 0 = bus_in
//   en_pc          in   decoder wants pc+4 driven as a link value
//   k              in   sign-extended word offset from the decoder
//   bus_in         in   datapath bus (register target or register offset)
//   next_state     in   decoder's micro-state for the next cycle
//   imem_data      in   instruction word from instruction memory
//   imem_ack       in   imem_data is valid this cycle
//   pc             out  current PC, also the instruction memory address
//   imem_req       out  fetch request (high for the whole FETCH phase)
//   instruction    out  instruction register, to the decoders
//   state          out  current micro-state, to the decoders
//   pc_plus4       out  pc + 4 (wrapping), combinational
//   pc_plus4_valid out  en_pc qualified by the EXEC phase
//   fetching       out  high while waiting for an instruction
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int                  PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          psel,
  input  logic                pc_sel,
  input  logic                en_pc,
  input  logic [PC_WIDTH-1:0] k,
  input  logic [PC_WIDTH-1:0] bus_in,
  input  logic [1:0]          next_state,
  input  logic [31:0]         imem_data,
  input  logic                imem_ack,
  output logic [PC_WIDTH-1:0] pc,
  output logic                imem_req,
  output logic [31:0]         instruction,
  output logic [1:0]          state,
  output logic [PC_WIDTH-1:0] pc_plus4,
  output logic                pc_plus4_valid,
  output logic                fetching
);

  typedef enum logic {
    PH_FETCH = 1'b0,
    PH_EXEC  = 1'b1
  } phase_t;

  localparam logic [1:0] PSEL_HOLD   = 2'b00;
  localparam logic [1:0] PSEL_INC    = 2'b01;
  localparam logic [1:0] PSEL_LOAD   = 2'b10;
  localparam logic [1:0] PSEL_BRANCH = 2'b11;

  localparam logic [1:0] STATE_IDLE = 2'b00;

  phase_t              phase, phase_nxt;
  logic [PC_WIDTH-1:0] pc_nxt;
  logic [31:0]         ir_nxt;
  logic [1:0]          state_nxt;
  logic [PC_WIDTH-1:0] branch_off;

  // Link value comes from the registered pc, so it stays correct in the very
  // cycle a branch overwrites pc.
  assign pc_plus4       = pc + PC_WIDTH'(4);
  assign imem_req       = (phase == PH_FETCH);
  assign fetching       = (phase == PH_FETCH);
  assign pc_plus4_valid = en_pc && (phase == PH_EXEC);

  assign branch_off = pc_sel ? k : bus_in;

  always_comb begin
    // NOTE: every signal gets a hold value before the case so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    phase_nxt = phase;
    pc_nxt    = pc;
    ir_nxt    = instruction;
    state_nxt = state;

    unique case (phase)
      PH_FETCH: begin
        // Decoder controls are meaningless here; only the ack matters.
        if (imem_ack) begin
          ir_nxt    = imem_data;
          state_nxt = STATE_IDLE;
          phase_nxt = PH_EXEC;
        end
      end
      PH_EXEC: begin
        // psel is deliberately not gated by micro-state: decoders hold it at
        // 00 in non-final micro-states themselves.
        unique case (psel)
          PSEL_HOLD:   pc_nxt = pc;
          PSEL_INC:    pc_nxt = pc_plus4;
          PSEL_LOAD:   pc_nxt = bus_in;
          // Left shift discards the top two offset bits; the add wraps.
          PSEL_BRANCH: pc_nxt = pc_plus4 + (branch_off << 2);
        endcase
        state_nxt = next_state;
        // The PC update above still lands, so the next fetch uses the new PC.
        if (next_state == STATE_IDLE) begin
          phase_nxt = PH_FETCH;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase       <= PH_FETCH;
      pc          <= RESET_PC;
      instruction <= 32'h0;
      state       <= STATE_IDLE;
    end else begin
      phase       <= phase_nxt;
      pc          <= pc_nxt;
      instruction <= ir_nxt;
      state       <= state_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed scenarios for fetch, sequential flow, branches, link value,
// multi-cycle instructions, stall, reset and wrap, followed by a randomized
// run checked against a behavioural model of the sequencer.
// Inputs are driven 1 time unit after the rising edge; combinational outputs
// are sampled 1 unit later and registered outputs 1 unit after each edge.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  psel;
  logic        pc_sel;
  logic        en_pc;
  logic [63:0] k;
  logic [63:0] bus_in;
  logic [1:0]  next_state;
  logic [31:0] imem_data;
  logic        imem_ack;
  logic [63:0] pc;
  logic        imem_req;
  logic [31:0] instruction;
  logic [1:0]  state;
  logic [63:0] pc_plus4;
  logic        pc_plus4_valid;
  logic        fetching;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  fetch_sequencer #(.PC_WIDTH(64), .RESET_PC(64'h0)) dut (
    .clock          (clock),
    .reset          (reset),
    .psel           (psel),
    .pc_sel         (pc_sel),
    .en_pc          (en_pc),
    .k              (k),
    .bus_in         (bus_in),
    .next_state     (next_state),
    .imem_data      (imem_data),
    .imem_ack       (imem_ack),
    .pc             (pc),
    .imem_req       (imem_req),
    .instruction    (instruction),
    .state          (state),
    .pc_plus4       (pc_plus4),
    .pc_plus4_valid (pc_plus4_valid),
    .fetching       (fetching)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] ps, input logic psl, input logic en,
                       input logic [63:0] kk, input logic [63:0] bi,
                       input logic [1:0] ns, input logic ack, input logic [31:0] dat);
    psel = ps; pc_sel = psl; en_pc = en; k = kk; bus_in = bi;
    next_state = ns; imem_ack = ack; imem_data = dat;
  endtask

  // Completes a fetch from FETCH with the given word.
  task automatic do_fetch(input logic [31:0] word);
    drive(2'b00, 1'b0, 1'b0, 64'h0, 64'h0, 2'b00, 1'b1, word);
    tick();
    imem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(2'b01, 1'b0, 1'b0, 64'h0, 64'h0, 2'b01, 1'b1, 32'hDEADBEEF);
    tick();
    reset = 1'b0;
    imem_ack = 1'b0;
    #1;
    n_cmp++; if (pc !== 64'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, 64'h0); end
    n_cmp++; if (instruction !== 32'h0) begin n_err++; $display("FAIL reset_ir: got %h want %h", instruction, 32'h0); end
    n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL reset_state: got %b want 00", state); end
    n_cmp++; if (fetching !== 1'b1) begin n_err++; $display("FAIL reset_fetching: got %b want 1", fetching); end
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL reset_req: got %b want 1", imem_req); end
  endtask

  task automatic test_fetch();
    drive(2'b00, 1'b0, 1'b0, 64'h0, 64'h0, 2'b00, 1'b1, 32'hB4000040);
    #1;
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL fetch_req: got %b want 1", imem_req); end
    n_cmp++; if (pc !== 64'h0) begin n_err++; $display("FAIL fetch_pc: got %h want 0", pc); end
    tick();
    imem_ack = 1'b0;
    n_cmp++; if (instruction !== 32'hB4000040) begin n_err++; $display("FAIL fetch_ir: got %h want B4000040", instruction); end
    n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL fetch_state: got %b want 00", state); end
    n_cmp++; if (fetching !== 1'b0) begin n_err++; $display("FAIL fetch_fetching: got %b want 0", fetching); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 1'b0, 1'b0, 64'h0, 64'h0, 2'b00, 1'b0, 32'h0);
      tick();
      n_cmp++; if (pc !== 64'(4 * (i + 1))) begin n_err++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc, 64'(4 * (i + 1))); end
      n_cmp++; if (fetching !== 1'b1 || imem_req !== 1'b1) begin n_err++; $display("FAIL seq_fetch[%0d]: got fetching=%b req=%b want 1/1", i, fetching, imem_req); end
      do_fetch(32'h8B000000 + 32'(i));
      n_cmp++; if (instruction !== 32'h8B000000 + 32'(i)) begin n_err++; $display("FAIL seq_ir[%0d]: got %h want %h", i, instruction, 32'h8B000000 + 32'(i)); end
    end
  endtask

  // Loads pc via psel=10 while staying in EXEC.
  task automatic load_pc(input logic [63:0] v);
    drive(2'b10, 1'b0, 1'b0, 64'h0, v, 2'b01, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_branch();
    load_pc(64'h100);
    n_cmp++; if (pc !== 64'h100) begin n_err++; $display("FAIL br_load: got %h want 100", pc); end
    drive(2'b11, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h7777, 2'b01, 1'b0, 32'h0);
    tick();
    n_cmp++; if (pc !== 64'h0FC) begin n_err++; $display("FAIL br_k_neg: got %h want 0fc", pc); end
    load_pc(64'h100);
    drive(2'b11, 1'b1, 1'b0, 64'd3, 64'h7777, 2'b01, 1'b0, 32'h0);
    tick();
    n_cmp++; if (pc !== 64'h110) begin n_err++; $display("FAIL br_k_pos: got %h want 110", pc); end
    load_pc(64'h100);
    drive(2'b11, 1'b0, 1'b0, 64'h5555, 64'd5, 2'b01, 1'b0, 32'h0);
    tick();
    n_cmp++; if (pc !== 64'h118) begin n_err++; $display("FAIL br_bus: got %h want 118", pc); end
    // Top two offset bits must vanish in the shift.
    load_pc(64'h100);
    drive(2'b11, 1'b1, 1'b0, 64'hC000_0000_0000_0001, 64'h0, 2'b01, 1'b0, 32'h0);
    tick();
    n_cmp++; if (pc !== 64'h108) begin n_err++; $display("FAIL br_topbits: got %h want 108", pc); end
  endtask

  task automatic test_register_branch_link();
    drive(2'b10, 1'b0, 1'b1, 64'h0, 64'h2000, 2'b00, 1'b0, 32'h0);
    #1;
    n_cmp++; if (pc_plus4_valid !== 1'b1) begin n_err++; $display("FAIL link_valid: got %b want 1", pc_plus4_valid); end
    n_cmp++; if (pc_plus4 !== 64'h10C) begin n_err++; $display("FAIL link_value: got %h want 10c", pc_plus4); end
    tick();
    n_cmp++; if (pc !== 64'h2000) begin n_err++; $display("FAIL regbr_pc: got %h want 2000", pc); end
    n_cmp++; if (pc_plus4_valid !== 1'b0) begin n_err++; $display("FAIL link_fetch_gate: got %b want 0", pc_plus4_valid); end
    en_pc = 1'b0;
    do_fetch(32'hD61F0000);
  endtask

  task automatic test_multicycle();
    logic [1:0] ns_seq [3] = '{2'b01, 2'b10, 2'b00};
    logic [1:0] ps_seq [3] = '{2'b00, 2'b00, 2'b01};
    logic [63:0] pc_exp [3] = '{64'h2000, 64'h2000, 64'h2004};
    for (int i = 0; i < 3; i++) begin
      drive(ps_seq[i], 1'b0, 1'b0, 64'h0, 64'h0, ns_seq[i], 1'b1, 32'hFFFF0000 + 32'(i));
      tick();
      n_cmp++; if (state !== ns_seq[i]) begin n_err++; $display("FAIL mc_state[%0d]: got %b want %b", i, state, ns_seq[i]); end
      n_cmp++; if (pc !== pc_exp[i]) begin n_err++; $display("FAIL mc_pc[%0d]: got %h want %h", i, pc, pc_exp[i]); end
      n_cmp++; if (instruction !== 32'hD61F0000) begin n_err++; $display("FAIL mc_ir[%0d]: got %h want d61f0000", i, instruction); end
    end
    imem_ack = 1'b0;
    n_cmp++; if (fetching !== 1'b1) begin n_err++; $display("FAIL mc_done: got %b want 1", fetching); end
  endtask

  task automatic test_stall_reset();
    for (int i = 0; i < 5; i++) begin
      drive(2'($urandom), 1'($urandom), 1'b0, {$urandom, $urandom}, {$urandom, $urandom},
            2'($urandom), 1'b0, $urandom);
      tick();
      n_cmp++; if (pc !== 64'h2004 || imem_req !== 1'b1 || state !== 2'b00 || instruction !== 32'hD61F0000) begin
        n_err++; $display("FAIL stall[%0d]: got pc=%h req=%b st=%b ir=%h want 2004/1/00/d61f0000", i, pc, imem_req, state, instruction);
      end
    end
    reset = 1'b1;
    drive(2'b01, 1'b0, 1'b0, 64'h0, 64'h0, 2'b01, 1'b1, 32'h12345678);
    tick();
    reset = 1'b0;
    imem_ack = 1'b0;
    n_cmp++; if (pc !== 64'h0 || instruction !== 32'h0 || fetching !== 1'b1 || state !== 2'b00) begin
      n_err++; $display("FAIL stall_reset: got pc=%h ir=%h fetching=%b st=%b want 0/0/1/00", pc, instruction, fetching, state);
    end
  endtask

  task automatic test_wrap();
    do_fetch(32'h91000000);
    load_pc(64'hFFFF_FFFF_FFFF_FFFC);
    drive(2'b01, 1'b0, 1'b0, 64'h0, 64'h0, 2'b00, 1'b0, 32'h0);
    #1;
    n_cmp++; if (pc_plus4 !== 64'h0) begin n_err++; $display("FAIL wrap_plus4: got %h want 0", pc_plus4); end
    tick();
    n_cmp++; if (pc !== 64'h0) begin n_err++; $display("FAIL wrap_pc: got %h want 0", pc); end
  endtask

  function automatic logic [63:0] rand_word();
    int s;
    if ($urandom_range(0, 1) == 0) begin
      s = int'($urandom_range(0, 64)) - 32;
      return 64'(longint'(s));
    end
    return {$urandom, $urandom};
  endfunction

  task automatic test_random();
    logic [63:0] m_pc;
    logic [31:0] m_ir;
    logic [1:0]  m_st;
    bit          m_exec;
    logic [63:0] off;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_pc = 64'h0; m_ir = 32'h0; m_st = 2'b00; m_exec = 1'b0;
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 31) == 0);
      drive(2'($urandom), 1'($urandom), 1'($urandom), rand_word(), rand_word(),
            2'($urandom), ($urandom_range(0, 2) == 0), $urandom);
      #1;
      n_cmp++; if (pc_plus4 !== m_pc + 64'd4 || pc_plus4_valid !== (en_pc && m_exec) || imem_req !== !m_exec) begin
        n_err++; $display("FAIL rnd_comb[%0d]: got p4=%h v=%b req=%b want %h/%b/%b", n, pc_plus4, pc_plus4_valid, imem_req, m_pc + 64'd4, en_pc && m_exec, !m_exec);
      end
      if (reset) begin
        m_pc = 64'h0; m_ir = 32'h0; m_st = 2'b00; m_exec = 1'b0;
      end else if (!m_exec) begin
        if (imem_ack) begin m_ir = imem_data; m_st = 2'b00; m_exec = 1'b1; end
      end else begin
        off = pc_sel ? k : bus_in;
        case (psel)
          2'b01:   m_pc = m_pc + 64'd4;
          2'b10:   m_pc = bus_in;
          2'b11:   m_pc = m_pc + 64'd4 + off * 64'd4;
          default: ;
        endcase
        m_st = next_state;
        if (next_state == 2'b00) m_exec = 1'b0;
      end
      tick();
      n_cmp++; if (pc !== m_pc || instruction !== m_ir || state !== m_st || fetching !== !m_exec) begin
        n_err++; $display("FAIL rnd_reg[%0d]: got pc=%h ir=%h st=%b f=%b want %h/%h/%b/%b", n, pc, instruction, state, fetching, m_pc, m_ir, m_st, !m_exec);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(2'b00, 1'b0, 1'b0, 64'h0, 64'h0, 2'b00, 1'b0, 32'h0);
    test_reset();
    test_fetch();
    test_sequential();
    test_branch();
    test_register_branch_link();
    test_multicycle();
    test_stall_reset();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
